// File: rtl/c_distribute_mofn.sv
// One-entry multi-destination distributor: an accepted word is held until every port in its
// select mask has taken it; each port drains independently.
module c_distribute_mofn #(
    parameter int unsigned num_ports = 4,
    parameter int unsigned width     = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [0:num_ports-1]         in_select,
    input  logic [0:width-1]             in_data,
    output logic [0:num_ports-1]         out_valid,
    input  logic [0:num_ports-1]         out_ready,
    output logic [0:num_ports*width-1]   out_data,
    output logic                         err_empty_select
);

    logic [0:width-1]     data_q, data_d;
    logic [0:num_ports-1] pend_q, pend_d;
    logic                 err_q, err_d;
    logic                 accept;

    always_comb begin
        // Ready once every still-pending port delivers this cycle; in_valid never feeds back.
        in_ready = ~|(pend_q & ~out_ready);
        accept   = in_valid & in_ready;
        pend_d   = pend_q & ~out_ready;
        data_d   = data_q;
        err_d    = 1'b0;
        if (accept) begin
            pend_d = in_select;
            data_d = in_data;
            err_d  = ~|in_select;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            data_q <= data_d;
            err_q  <= err_d;
        end
    end

    assign out_valid        = pend_q;
    assign err_empty_select = err_q;

    for (genvar j = 0; j < num_ports; j++) begin : g_port
        assign out_data[j*width +: width] = data_q & {width{pend_q[j]}};
    end

endmodule
